// File: rtl/kamacore_hazard_controller.sv
// rtl/kamacore_hazard_controller.sv - load-use scoreboard, mem-wait and redirect sequencing for the five-stage pipeline
// Optional KAMACORE_HAZARD_PERF_EN adds stall_cycles/flush_cycles counters.
module kamacore_hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]       id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]       id_rs2,
    input  logic                            id_uses_rs1,
    input  logic                            id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]       id_rd,
    input  logic                            id_write_rd,
    input  logic                            id_memory_read,
    input  logic                            mem_req,
    input  logic                            mem_ready,
    input  logic                            ex_redirect,
    input  logic                            wb_write_register,
    input  logic [REG_ADDR_WIDTH-1:0]       wb_rd,
    output logic                            hold_if,
    output logic                            hold_id,
    output logic                            hold_ex,
    output logic                            hold_mem,
    output logic                            bubble_ex,
    output logic                            flush_if_id,
`ifdef KAMACORE_HAZARD_PERF_EN
    output logic [31:0]                     stall_cycles,
    output logic [31:0]                     flush_cycles,
`endif
    output logic [(1<<REG_ADDR_WIDTH)-1:0]  busy_regs
);
    localparam int         NREGS        = 1 << REG_ADDR_WIDTH;
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {RUN, WAIT_MEM, FLUSH} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_flush_cnt, w_flush_cnt_nxt;
    logic [NREGS-1:0] r_busy, w_busy_nxt, w_wb_clr, w_busy_eff, w_set;
    logic             w_mem_stall, w_hazard, w_issue, w_run_like;
    logic             w_hold_if, w_hold_id, w_hold_ex, w_hold_mem, w_bubble, w_flush;

    // Writeback in this cycle already frees its register for the hazard check
    always_comb begin
        w_wb_clr   = wb_write_register ? (NREGS'(1) << wb_rd) : '0;
        w_busy_eff = r_busy & ~w_wb_clr;
        w_hazard   = id_valid &&
                     ((id_uses_rs1 && (id_rs1 != '0) && w_busy_eff[id_rs1]) ||
                      (id_uses_rs2 && (id_rs2 != '0) && w_busy_eff[id_rs2]));
    end

    assign w_mem_stall = mem_req && !mem_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_hold_if       = 1'b0;
        w_hold_id       = 1'b0;
        w_hold_ex       = 1'b0;
        w_hold_mem      = 1'b0;
        w_bubble        = 1'b0;
        w_flush         = 1'b0;
        w_run_like      = 1'b0;
        if (w_mem_stall) begin
            w_hold_if   = 1'b1;
            w_hold_id   = 1'b1;
            w_hold_ex   = 1'b1;
            w_hold_mem  = 1'b1;
            w_state_nxt = WAIT_MEM;
        end else if (ex_redirect) begin
            w_flush         = 1'b1;
            w_bubble        = 1'b1;
            w_flush_cnt_nxt = FLUSH_RELOAD;
            w_state_nxt     = (FLUSH_RELOAD != 4'd0) ? FLUSH : RUN;
        end else begin
            case (r_state)
                FLUSH: begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_flush_cnt > 4'd1) begin
                        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                    end else begin
                        w_flush_cnt_nxt = 4'd0;
                        w_state_nxt     = RUN;
                    end
                end
                WAIT_MEM: begin
                    // A flush interrupted by the memory wait resumes without losing a cycle of squash
                    if (r_flush_cnt != 4'd0) begin
                        w_flush     = 1'b1;
                        w_bubble    = 1'b1;
                        w_state_nxt = FLUSH;
                    end else begin
                        w_run_like  = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                default: w_run_like = 1'b1;
            endcase
            if (w_run_like && w_hazard) begin
                w_hold_if = 1'b1;
                w_hold_id = 1'b1;
                w_bubble  = 1'b1;
            end
        end
    end

    assign hold_if     = !rst && w_hold_if;
    assign hold_id     = !rst && w_hold_id;
    assign hold_ex     = !rst && w_hold_ex;
    assign hold_mem    = !rst && w_hold_mem;
    assign bubble_ex   = !rst && w_bubble;
    assign flush_if_id = !rst && w_flush;

    assign w_issue = id_valid && !hold_id && !flush_if_id;

    always_comb begin
        w_set = (w_issue && id_memory_read && id_write_rd && (id_rd != '0))
                ? (NREGS'(1) << id_rd) : '0;
        w_busy_nxt    = (r_busy & ~w_wb_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_flush_cnt <= 4'd0;
            r_busy      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign busy_regs = r_busy;

`ifdef KAMACORE_HAZARD_PERF_EN
    logic [31:0] r_stall_cycles, r_flush_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_cycles <= 32'd0;
        end else begin
            if (hold_id)     r_stall_cycles <= r_stall_cycles + 32'd1;
            if (flush_if_id) r_flush_cycles <= r_flush_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif
endmodule

// File: tb/tb_kamacore_hazard_controller.sv
// tb/tb_kamacore_hazard_controller.sv - directed scoreboard bench for kamacore_hazard_controller
module tb_kamacore_hazard_controller;
    localparam int RAW = 5;
    localparam int NR  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           id_valid, id_uses_rs1, id_uses_rs2, id_write_rd, id_memory_read;
    logic [RAW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic           mem_req, mem_ready, ex_redirect, wb_write_register;
    logic           hold_if, hold_id, hold_ex, hold_mem, bubble_ex, flush_if_id;
    logic [NR-1:0]  busy_regs;
`ifdef KAMACORE_HAZARD_PERF_EN
    logic [31:0]    stall_cycles, flush_cycles;
`endif

    kamacore_hazard_controller #(.REG_ADDR_WIDTH(RAW), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_write_rd(id_write_rd), .id_memory_read(id_memory_read),
        .mem_req(mem_req), .mem_ready(mem_ready), .ex_redirect(ex_redirect),
        .wb_write_register(wb_write_register), .wb_rd(wb_rd),
        .hold_if(hold_if), .hold_id(hold_id), .hold_ex(hold_ex), .hold_mem(hold_mem),
        .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
`ifdef KAMACORE_HAZARD_PERF_EN
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
`endif
        .busy_regs(busy_regs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]    ctl;
        logic [NR-1:0] busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    // ctl order: {hold_if, hold_id, hold_ex, hold_mem, bubble_ex, flush_if_id}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_LUSE  = 6'b110010;
    localparam logic [5:0] C_MEM   = 6'b111100;
    localparam logic [5:0] C_FLUSH = 6'b000011;

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_write_rd = 0; id_memory_read = 0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; wb_rd = '0;
        mem_req = 0; mem_ready = 0; ex_redirect = 0; wb_write_register = 0;
    endtask

    task automatic load(input logic [RAW-1:0] rd);
        id_valid = 1; id_memory_read = 1; id_write_rd = 1; id_rd = rd;
    endtask

    task automatic chk(input logic [5:0] ctl, input logic [NR-1:0] busy, input string tag);
        exp_t       e;
        logic [5:0] obs;
        e.ctl  = ctl;
        e.busy = busy;
        q.push_back(e);
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            exp_stall += int'(ctl[4]);
            exp_flush += int'(ctl[0]);
        end
        @(negedge clk);
        e   = q.pop_front();
        obs = {hold_if, hold_id, hold_ex, hold_mem, bubble_ex, flush_if_id};
        checks++;
        assert (obs === e.ctl) else begin
            errors++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, e.ctl);
        end
        checks++;
        assert (busy_regs === e.busy) else begin
            errors++;
            $error("FAIL %s busy observed=%h expected=%h", tag, busy_regs, e.busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            id_valid = 1'($urandom); id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            id_write_rd = 1'($urandom); id_memory_read = 1'($urandom);
            id_rs1 = RAW'($urandom); id_rs2 = RAW'($urandom); id_rd = RAW'($urandom);
            mem_req = 1'($urandom); mem_ready = 1'($urandom); ex_redirect = 1'($urandom);
            wb_write_register = 1'($urandom); wb_rd = RAW'($urandom);
            chk(C_NONE, '0, "reset_random");
        end
        @(posedge clk); #1;
        rst = 0;
        idle();
        chk(C_NONE, '0, "idle_after_reset");
        chk(C_NONE, '0, "idle_after_reset2");

        // load x5 then dependent use of x5, writeback two cycles later
        load(5);
        chk(C_NONE, '0, "load5_issue");
        idle(); id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5;
        chk(C_LUSE, NR'(1) << 5, "luse_stall1");
        chk(C_LUSE, NR'(1) << 5, "luse_stall2");
        wb_write_register = 1; wb_rd = 5;
        chk(C_NONE, NR'(1) << 5, "luse_wb_bypass");
        idle();
        chk(C_NONE, '0, "busy5_cleared");

        // x0 is never scoreboarded
        load(0);
        chk(C_NONE, '0, "load_x0");
        idle(); id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
        chk(C_NONE, '0, "use_x0");

        // rs2 dependency, with the use flag as the qualifier
        idle(); load(7);
        chk(C_NONE, '0, "load7_issue");
        idle(); id_valid = 1; id_uses_rs1 = 1; id_rs1 = 3; id_rs2 = 7;
        chk(C_NONE, NR'(1) << 7, "rs2_unused_no_stall");
        id_uses_rs2 = 1;
        chk(C_LUSE, NR'(1) << 7, "rs2_stall");
        wb_write_register = 1; wb_rd = 7;
        chk(C_NONE, NR'(1) << 7, "rs2_wb_bypass");
        idle();
        chk(C_NONE, '0, "busy7_cleared");

        // set and clear of the same entry: set wins
        load(9); wb_write_register = 1; wb_rd = 9;
        chk(C_NONE, '0, "set_clr_same");
        idle();
        chk(C_NONE, NR'(1) << 9, "set_wins");
        wb_write_register = 1; wb_rd = 9;
        chk(C_NONE, NR'(1) << 9, "wb9");
        idle();
        chk(C_NONE, '0, "busy9_cleared");

        // mem stall with a redirect held high: redirect waits for mem_ready
        mem_req = 1; ex_redirect = 1;
        chk(C_MEM, '0, "mem_stall1");
        chk(C_MEM, '0, "mem_stall2");
        chk(C_MEM, '0, "mem_stall3");
        mem_ready = 1;
        chk(C_FLUSH, '0, "mem_done_redirect");
        idle();
        chk(C_FLUSH, '0, "post_mem_flush2");
        chk(C_NONE, '0, "post_mem_run");

        // plain redirect; a load in ID during the flush must not issue
        ex_redirect = 1;
        chk(C_FLUSH, '0, "redirect1");
        idle(); load(12);
        chk(C_FLUSH, '0, "redirect2_load_squashed");
        idle();
        chk(C_NONE, '0, "redirect_done");
        chk(C_NONE, '0, "redirect_no_busy");

        // asynchronous reset in the middle of a redirect
        load(3);
        chk(C_NONE, '0, "load3_issue");
        idle(); ex_redirect = 1; rst = 1;
        chk(C_NONE, '0, "mid_reset");
        rst = 0; idle();
        chk(C_NONE, '0, "after_mid_reset");

        // one more stall and flush for the perf counters
        load(4);
        chk(C_NONE, '0, "load4_issue");
        idle(); id_valid = 1; id_uses_rs2 = 1; id_rs2 = 4;
        chk(C_LUSE, NR'(1) << 4, "perf_stall1");
        chk(C_LUSE, NR'(1) << 4, "perf_stall2");
        idle(); wb_write_register = 1; wb_rd = 4; ex_redirect = 1;
        chk(C_FLUSH, NR'(1) << 4, "perf_redirect");
        idle();
        chk(C_FLUSH, '0, "perf_flush2");
        chk(C_NONE, '0, "perf_idle");
`ifdef KAMACORE_HAZARD_PERF_EN
        @(negedge clk);
        checks++;
        assert (stall_cycles === 32'(exp_stall)) else begin
            errors++;
            $error("FAIL stall_cycles observed=%0d expected=%0d", stall_cycles, exp_stall);
        end
        checks++;
        assert (flush_cycles === 32'(exp_flush)) else begin
            errors++;
            $error("FAIL flush_cycles observed=%0d expected=%0d", flush_cycles, exp_flush);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
